mdu: RTL



---
 rtl/mdu_if.sv | 22 ++
 rtl/mdu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
// The pipeline drives the master side; the MDU implements the slave side.
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, hi, lo
   );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Operands are latched at accept and the result commits on the last busy edge.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam int unsigned MAXC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = $clog2(MAXC + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t MULT_N = cnt_t'(MULT_CYCLES);
   localparam cnt_t DIV_N  = cnt_t'(DIV_CYCLES);
   localparam cnt_t ONE    = cnt_t'(1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   cnt_t        count_q, count_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        accept;
   logic        is_mul;
   logic        mul_sgn;
   logic        div_sgn;
   logic signed [32:0] mul_a;
   logic signed [32:0] mul_b;
   logic signed [65:0] prod;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] den;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quo;
   logic [31:0] rem;

   // Result is computed from the latched operands, so input wiggles are harmless.
   always_comb begin
      is_mul  = ~op_q[1];
      mul_sgn = (op_q == OP_MULT[1:0]);
      div_sgn = (op_q == OP_DIV[1:0]);
      mul_a   = {mul_sgn & a_q[31], a_q};
      mul_b   = {mul_sgn & b_q[31], b_q};
      prod    = mul_a * mul_b;
      a_neg   = div_sgn & a_q[31];
      b_neg   = div_sgn & b_q[31];
      a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
      b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
      den     = (b_mag == 32'd0) ? 32'd1 : b_mag;
      uq      = a_mag / den;
      ur      = a_mag % den;
      quo     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
      rem     = a_neg ? (~ur + 32'd1) : ur;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      accept  = bus.start & ~bus.flush & (state_q == IDLE);
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (bus.op)
                  OP_MULT, OP_MULTU: begin
                     state_d = RUN;
                     count_d = MULT_N;
                     op_d    = bus.op[1:0];
                     a_d     = bus.a;
                     b_d     = bus.b;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = RUN;
                     count_d = DIV_N;
                     op_d    = bus.op[1:0];
                     a_d     = bus.a;
                     b_d     = bus.b;
                  end
                  OP_MTHI: hi_d = bus.a;
                  OP_MTLO: lo_d = bus.a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            count_d = count_q - ONE;
            if (count_q == ONE) begin
               state_d = IDLE;
               if (is_mul) begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end else if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = (count_q != '0);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
